// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller slice.
package stopwatch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        PAUSE,
        EXPIRED,
        LOAD
    } sw_state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector: one-cycle pulse on each low-to-high transition of a level.
module edge_pulse (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic pulse
);

    logic in_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            in_prev <= 1'b0;
        end else begin
            in_prev <= in;
        end
    end

    assign pulse = in & ~in_prev;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Sequencer for a cascaded BCD digit chain: buttons and timebase tick in,
// per-digit enables, shared direction and shared load out.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tick,
    input  logic                    btn_start,
    input  logic                    btn_clear,
    input  logic                    count_down,
    input  logic [4*NUM_DIGITS-1:0] preset_bcd,
    input  logic [4*NUM_DIGITS-1:0] digit_q,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    digit_up,
    output logic                    digit_load,
    output logic [4*NUM_DIGITS-1:0] load_value,
    output logic                    running,
    output logic                    expired,
    output sw_state_t               state_dbg
);

    sw_state_t state;
    logic      dir_q;
    logic      start_evt;
    logic      clear_evt;
    logic [3:0] term;
    logic [NUM_DIGITS:0] prefix_t;
    logic      all_t;
    logic      digits_zero;

    edge_pulse u_start_edge (
        .clk   (clk),
        .reset (reset),
        .in    (btn_start),
        .pulse (start_evt)
    );

    edge_pulse u_clear_edge (
        .clk   (clk),
        .reset (reset),
        .in    (btn_clear),
        .pulse (clear_evt)
    );

    assign term = dir_q ? BCD_MIN : BCD_MAX;

    // prefix_t[i] is true when digits 0..i-1 all sit at the terminal value,
    // which is exactly the cascade enable for digit i.
    always_comb begin
        prefix_t    = '0;
        prefix_t[0] = 1'b1;
        digits_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            prefix_t[i+1] = prefix_t[i] & (digit_q[4*i +: 4] == term);
            digits_zero   = digits_zero & (digit_q[4*i +: 4] == BCD_MIN);
        end
    end

    assign all_t = prefix_t[NUM_DIGITS];

    always_comb begin
        digit_en   = '0;
        digit_load = 1'b0;
        load_value = '0;
        case (state)
            RUN: begin
                if (tick && !clear_evt && !start_evt && !all_t) begin
                    digit_en = prefix_t[NUM_DIGITS-1:0];
                end
            end
            LOAD: begin
                digit_load = 1'b1;
                digit_en   = '1;
                load_value = dir_q ? preset_bcd : '0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            dir_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    dir_q <= count_down;
                    if (clear_evt) begin
                        state <= LOAD;
                    end else if (start_evt) begin
                        state <= (count_down && digits_zero) ? EXPIRED : RUN;
                    end
                end
                RUN: begin
                    if (clear_evt) begin
                        state <= LOAD;
                    end else if (start_evt) begin
                        state <= PAUSE;
                    end else if (tick && all_t) begin
                        state <= EXPIRED;
                    end
                end
                PAUSE: begin
                    if (clear_evt) begin
                        state <= LOAD;
                    end else if (start_evt) begin
                        state <= RUN;
                    end
                end
                EXPIRED: begin
                    if (clear_evt) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign digit_up  = ~dir_q;
    assign running   = (state == RUN);
    assign expired   = (state == EXPIRED);
    assign state_dbg = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl driving a behavioural 4-digit BCD counter chain.
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    localparam int ND = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            tick;
    logic            btn_start;
    logic            btn_clear;
    logic            count_down;
    logic [4*ND-1:0] preset_bcd;
    logic [4*ND-1:0] digit_q;
    logic [ND-1:0]   digit_en;
    logic            digit_up;
    logic            digit_load;
    logic [4*ND-1:0] load_value;
    logic            running;
    logic            expired;
    sw_state_t       state_dbg;

    logic            force_en;
    logic [4*ND-1:0] force_val;
    logic [4*ND-1:0] cnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    stopwatch_ctrl #(.NUM_DIGITS(ND)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .btn_start  (btn_start),
        .btn_clear  (btn_clear),
        .count_down (count_down),
        .preset_bcd (preset_bcd),
        .digit_q    (digit_q),
        .digit_en   (digit_en),
        .digit_up   (digit_up),
        .digit_load (digit_load),
        .load_value (load_value),
        .running    (running),
        .expired    (expired),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    // BCD digit chain the controller sequences
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (force_en) begin
            cnt <= force_val;
        end else begin
            for (int i = 0; i < ND; i++) begin
                if (digit_en[i]) begin
                    if (digit_load) begin
                        cnt[4*i +: 4] <= load_value[4*i +: 4];
                    end else if (digit_up) begin
                        cnt[4*i +: 4] <= (cnt[4*i +: 4] == 4'd9) ? 4'd0 : cnt[4*i +: 4] + 4'd1;
                    end else begin
                        cnt[4*i +: 4] <= (cnt[4*i +: 4] == 4'd0) ? 4'd9 : cnt[4*i +: 4] - 4'd1;
                    end
                end
            end
        end
    end

    assign digit_q = cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic press_start();
        btn_start = 1'b1;
        cyc();
        btn_start = 1'b0;
        cyc();
    endtask

    task automatic press_clear();
        btn_clear = 1'b1;
        cyc();
        btn_clear = 1'b0;
        cyc();
    endtask

    task automatic set_digits(input logic [4*ND-1:0] v);
        force_val = v;
        force_en  = 1'b1;
        cyc();
        force_en  = 1'b0;
    endtask

    // one tick cycle: check the enables presented with it, then clock it in
    task automatic tick_check(input string tag, input logic [ND-1:0] exp_en);
        tick = 1'b1;
        #1;
        check(tag, digit_en, exp_en);
        cyc();
        tick = 1'b0;
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; btn_start = 1'b0; btn_clear = 1'b0;
        count_down = 1'b0; preset_bcd = '0; force_en = 1'b0; force_val = '0;
        repeat (2) cyc();
        reset = 1'b0;

        // reset state
        check("rst_state", state_dbg, IDLE);
        check("rst_en", digit_en, 4'b0000);
        check("rst_load", digit_load, 1'b0);
        check("rst_lval", load_value, 16'h0000);
        check("rst_running", running, 1'b0);
        check("rst_expired", expired, 1'b0);
        check("rst_up", digit_up, 1'b1);

        // count up 12 ticks from 0000
        press_start();
        check("run_after_start", running, 1'b1);
        for (int k = 0; k < 12; k++) exp_q.push_back((k == 9) ? 32'h3 : 32'h1);
        for (int k = 0; k < 12; k++) tick_check("up12_en", exp_q.pop_front());
        check("up12_digits", cnt, 16'h0012);
        check("up12_running", running, 1'b1);

        // 0999 -> 1000 full cascade
        press_start();
        check("pause_state", state_dbg, PAUSE);
        set_digits(16'h0999);
        press_start();
        tick_check("cascade_en", 4'b1111);
        check("cascade_digits", cnt, 16'h1000);

        // start coincident with tick drops the tick
        btn_start = 1'b1;
        tick_check("start_tick_en", 4'b0000);
        btn_start = 1'b0;
        check("start_tick_state", state_dbg, PAUSE);
        check("start_tick_digits", cnt, 16'h1000);
        for (int k = 0; k < 3; k++) tick_check("pause_tick_en", 4'b0000);
        check("pause_digits", cnt, 16'h1000);
        press_start();
        check("resume_running", running, 1'b1);
        tick_check("resume_en", 4'b0001);
        check("resume_digits", cnt, 16'h1001);

        // saturate at 9999
        press_start();
        set_digits(16'h9999);
        press_start();
        tick_check("sat_en", 4'b0000);
        check("sat_expired", expired, 1'b1);
        check("sat_digits", cnt, 16'h9999);
        press_start();
        check("sat_start_ignored", state_dbg, EXPIRED);
        btn_clear = 1'b1;
        cyc();
        btn_clear = 1'b0;
        check("sat_clr_state", state_dbg, LOAD);
        check("sat_clr_load", digit_load, 1'b1);
        check("sat_clr_en", digit_en, 4'b1111);
        check("sat_clr_lval", load_value, 16'h0000);
        cyc();
        check("sat_clr_idle", state_dbg, IDLE);
        check("sat_clr_digits", cnt, 16'h0000);
        check("sat_clr_load_off", digit_load, 1'b0);

        // countdown from preset 0003
        count_down = 1'b1;
        preset_bcd = 16'h0003;
        cyc();
        btn_clear = 1'b1;
        cyc();
        btn_clear = 1'b0;
        check("dn_load", digit_load, 1'b1);
        check("dn_lval", load_value, 16'h0003);
        check("dn_up", digit_up, 1'b0);
        cyc();
        check("dn_load_one_cycle", digit_load, 1'b0);
        check("dn_loaded", cnt, 16'h0003);
        press_start();
        check("dn_running", running, 1'b1);
        tick_check("dn_t1", 4'b0001);
        check("dn_d1", cnt, 16'h0002);
        tick_check("dn_t2", 4'b0001);
        check("dn_d2", cnt, 16'h0001);
        tick_check("dn_t3", 4'b0001);
        check("dn_d3", cnt, 16'h0000);
        tick_check("dn_t4", 4'b0000);
        check("dn_expired", expired, 1'b1);
        check("dn_hold", cnt, 16'h0000);

        // countdown start with all-zero digits goes straight to EXPIRED
        preset_bcd = 16'h0000;
        press_clear();
        check("zero_idle", state_dbg, IDLE);
        press_start();
        check("zero_expired", expired, 1'b1);

        // clear wins over start; direction frozen outside IDLE
        count_down = 1'b0;
        press_clear();
        cyc();
        press_start();
        check("dir_run", running, 1'b1);
        check("dir_up", digit_up, 1'b1);
        count_down = 1'b1;
        cyc();
        check("dir_frozen", digit_up, 1'b1);
        btn_start = 1'b1;
        btn_clear = 1'b1;
        cyc();
        btn_start = 1'b0;
        btn_clear = 1'b0;
        check("both_state", state_dbg, LOAD);
        check("both_load", digit_load, 1'b1);
        cyc();
        check("both_idle", state_dbg, IDLE);

        // held start button toggles once
        count_down = 1'b0;
        cyc();
        btn_start = 1'b1;
        repeat (20) cyc();
        check("held_state", state_dbg, RUN);
        check("held_running", running, 1'b1);
        btn_start = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
